alu_arbiter: RTL

Shares one alu_4bit instance between NREQ requesters. Each requester issues {A, B, op} over a valid/ready handshake. A round-robin arbiter grants one request, the operands are registered, and the ALU output is captured. The result is returned on a single response channel tagged with the requester id. The block sits between the requester masters and the ALU, and is the only driver of the ALU inputs.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_4bit.sv | 29 ++
 rtl/alu_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcodes and the arbiter FSM state encoding.
package alu_pkg;

    localparam int unsigned ALU_W = 4;
    localparam int unsigned OP_W  = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Opcodes past OP_NOT have no ALU function and are flagged as errors.
    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return op > OP_NOT;
    endfunction

endpackage

// File: rtl/alu_4bit.sv
// 4-bit combinational ALU; carry doubles as borrow for subtraction.
module alu_4bit
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  logic [OP_W-1:0]  con,
    output logic [ALU_W-1:0] Result,
    output logic             carry
);

    always_comb begin
        Result = '0;
        carry  = 1'b0;
        case (con)
            OP_ADD:  {carry, Result} = {1'b0, A} + {1'b0, B};
            OP_SUB:  {carry, Result} = {1'b0, A} - {1'b0, B};
            OP_AND:  Result = A & B;
            OP_OR:   Result = A | B;
            OP_XOR:  Result = A ^ B;
            OP_NOT:  Result = ~A;
            default: begin
                Result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_4bit between NREQ valid/ready requesters,
// returning each result on a single id-tagged response channel.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [ALU_W*NREQ-1:0]  req_a,
    input  logic [ALU_W*NREQ-1:0]  req_b,
    input  logic [OP_W*NREQ-1:0]   req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [ALU_W-1:0]       rsp_result,
    output logic                   rsp_carry,
    output logic                   rsp_err,
    output logic                   busy
);

    state_t             r_state;
    state_t             w_next_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_gnt;
    logic [ALU_W-1:0]   r_a;
    logic [ALU_W-1:0]   r_b;
    logic [OP_W-1:0]    r_op;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [ALU_W-1:0]   r_rsp_result;
    logic               r_rsp_carry;
    logic               r_rsp_err;
    logic               r_busy;

    logic               w_pick_vld;
    logic [IDW-1:0]     w_gnt;
    logic [IDW-1:0]     w_ptr_nxt;
    logic [ALU_W-1:0]   w_alu_res;
    logic               w_alu_carry;

    // First valid requester at or after ptr, wrapping modulo NREQ; MSB flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % int'(NREQ);
            if (valid[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    assign {w_pick_vld, w_gnt} = rr_pick(req_valid, r_rr_ptr);
    assign w_ptr_nxt = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    req_ready[w_gnt] = 1'b1;
                    w_next_state     = EXEC;
                end
            end
            EXEC:    w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Operand latch, pointer update and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_gnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_busy <= (w_next_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_a      <= req_a[ALU_W*int'(w_gnt) +: ALU_W];
                        r_b      <= req_b[ALU_W*int'(w_gnt) +: ALU_W];
                        r_op     <= req_op[OP_W*int'(w_gnt) +: OP_W];
                        r_gnt    <= w_gnt;
                        r_rr_ptr <= w_ptr_nxt;
                    end
                end
                EXEC: begin
                    r_rsp_result <= w_alu_res;
                    r_rsp_carry  <= w_alu_carry;
                    r_rsp_err    <= op_illegal(r_op);
                    r_rsp_id     <= r_gnt;
                    r_rsp_valid  <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    alu_4bit u_alu (
        .A      (r_a),
        .B      (r_b),
        .con    (r_op),
        .Result (w_alu_res),
        .carry  (w_alu_carry)
    );

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_err    = r_rsp_err;
    assign busy       = r_busy;

endmodule
